// File: rtl/mcp_multiplier_ctrl_if.sv
// Handshake bundle for mcp_multiplier_ctrl: operand side (A/B/In_*) and result side (Result/Out_*).
// Signed_Mode exists only when MCP_MULT_SIGNED_EN is defined.
interface mcp_multiplier_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               In_Valid;
    logic               In_Ready;
    logic [2*WIDTH-1:0] Result;
    logic               Out_Valid;
    logic               Out_Ready;
    logic               Busy;
`ifdef MCP_MULT_SIGNED_EN
    logic               Signed_Mode;
`endif

    modport master (
        output A, B, In_Valid, Out_Ready,
`ifdef MCP_MULT_SIGNED_EN
        output Signed_Mode,
`endif
        input  In_Ready, Result, Out_Valid, Busy
    );

    modport slave (
        input  A, B, In_Valid, Out_Ready,
`ifdef MCP_MULT_SIGNED_EN
        input  Signed_Mode,
`endif
        output In_Ready, Result, Out_Valid, Busy
    );
endinterface

// File: rtl/mcp_multiplier_ctrl.sv
// Multicycle-path multiplier wrapper: operands registered on accept, product captured MC_CYCLES later.
// Optional macro MCP_MULT_SIGNED_EN adds a per-operation two's-complement mode (Signed_Mode).
module mcp_multiplier_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MC_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    mcp_multiplier_ctrl_if.slave bus
);
    localparam int                CNT_W    = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   ra_q, ra_d;
    logic [WIDTH-1:0]   rb_q, rb_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               accept;
    logic               capture;
`ifdef MCP_MULT_SIGNED_EN
    logic               rsigned_q, rsigned_d;
`endif

`ifdef MCP_MULT_SIGNED_EN
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        logic signed [2*WIDTH-1:0] p;
        ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        p  = ea * eb;
        return p;
    endfunction
`else
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = {{WIDTH{1'b0}}, a};
        eb = {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction
`endif

    // With MC_CYCLES=1 the counter loads 0, so the first WAIT edge is already the capture edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        result_d = result_q;
        accept   = 1'b0;
        capture  = 1'b0;
`ifdef MCP_MULT_SIGNED_EN
        rsigned_d = rsigned_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.In_Valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.Out_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Plain load enables keep rA/rB -> Result a clean multicycle path.
        if (accept) begin
            ra_d = bus.A;
            rb_d = bus.B;
`ifdef MCP_MULT_SIGNED_EN
            rsigned_d = bus.Signed_Mode;
`endif
        end
        if (capture) begin
`ifdef MCP_MULT_SIGNED_EN
            result_d = mul_full(ra_q, rb_q, rsigned_q);
`else
            result_d = mul_full(ra_q, rb_q);
`endif
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            result_q <= '0;
`ifdef MCP_MULT_SIGNED_EN
            rsigned_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            result_q <= result_d;
`ifdef MCP_MULT_SIGNED_EN
            rsigned_q <= rsigned_d;
`endif
        end
    end

    assign bus.In_Ready  = (state_q == IDLE);
    assign bus.Out_Valid = (state_q == DONE);
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Result    = result_q;
endmodule

// File: tb/tb_mcp_multiplier_ctrl.sv
// Bench for mcp_multiplier_ctrl: an 8-bit/4-cycle instance and a 16-bit/1-cycle instance
// driven with directed and randomized operations, checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_mcp_multiplier_ctrl;
    localparam int W0 = 8;
    localparam int M0 = 4;
    localparam int W1 = 16;
    localparam int M1 = 1;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int   cmp  = 0;
    int   err  = 0;

    always #5 CLK = ~CLK;

    mcp_multiplier_ctrl_if #(.WIDTH(W0)) bus0();
    mcp_multiplier_ctrl_if #(.WIDTH(W1)) bus1();

    mcp_multiplier_ctrl #(.WIDTH(W0), .MC_CYCLES(M0)) dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
    mcp_multiplier_ctrl #(.WIDTH(W1), .MC_CYCLES(M1)) dut1 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full-width product of two w-bit operands, optionally as two's complement.
    function automatic longint unsigned ref_mul(longint unsigned a, longint unsigned b, int w, bit sgn);
        longint sa;
        longint sb;
        longint unsigned mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn) begin
            if (a >= (64'd1 << (w - 1))) sa = sa - longint'(64'd1 << w);
            if (b >= (64'd1 << (w - 1))) sb = sb - longint'(64'd1 << w);
        end
        return longint'(sa * sb) & mask;
    endfunction

    task automatic test_reset();
        repeat (3) tick();
        cmp++;
        if (bus0.In_Ready !== 1'b1 || bus0.Out_Valid !== 1'b0 || bus0.Busy !== 1'b0 || bus0.Result !== 16'h0) begin
            err++;
            $display("FAIL reset_dut0: In_Ready=%b Out_Valid=%b Busy=%b Result=%h, want 1 0 0 0000",
                     bus0.In_Ready, bus0.Out_Valid, bus0.Busy, bus0.Result);
        end
        cmp++;
        if (bus1.In_Ready !== 1'b1 || bus1.Out_Valid !== 1'b0 || bus1.Result !== 32'h0) begin
            err++;
            $display("FAIL reset_dut1: In_Ready=%b Out_Valid=%b Result=%h, want 1 0 00000000",
                     bus1.In_Ready, bus1.Out_Valid, bus1.Result);
        end
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        bus0.A = 8'd255; bus0.B = 8'd255; bus0.In_Valid = 1'b1;
        tick();
        bus0.In_Valid = 1'b0;
        cmp++;
        if (bus0.In_Ready !== 1'b0 || bus0.Busy !== 1'b1) begin
            err++;
            $display("FAIL accept_state: In_Ready=%b Busy=%b, want 0 1", bus0.In_Ready, bus0.Busy);
        end
        for (int i = 1; i <= M0; i++) begin
            tick();
            cmp++;
            if (bus0.Out_Valid !== (i == M0) || bus0.In_Ready !== 1'b0) begin
                err++;
                $display("FAIL latency_edge%0d: Out_Valid=%b In_Ready=%b, want %b 0",
                         i, bus0.Out_Valid, bus0.In_Ready, (i == M0));
            end
        end
        cmp++;
        if (bus0.Result !== 16'hFE01) begin
            err++;
            $display("FAIL product_ff: Result=%h, want fe01", bus0.Result);
        end
    endtask

    task automatic test_hold();
        bus0.A = 8'd3; bus0.B = 8'd5; bus0.In_Valid = 1'b1; bus0.Out_Ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp++;
            if (bus0.Out_Valid !== 1'b1 || bus0.Result !== 16'hFE01 || bus0.In_Ready !== 1'b0) begin
                err++;
                $display("FAIL hold_%0d: Out_Valid=%b Result=%h In_Ready=%b, want 1 fe01 0",
                         i, bus0.Out_Valid, bus0.Result, bus0.In_Ready);
            end
        end
        bus0.Out_Ready = 1'b1;
        #1;
        cmp++;
        if (bus0.In_Ready !== 1'b0) begin
            err++;
            $display("FAIL no_same_cycle_ready: In_Ready=%b, want 0", bus0.In_Ready);
        end
        tick();
        bus0.Out_Ready = 1'b0;
        bus0.In_Valid  = 1'b0;
        cmp++;
        if (bus0.Out_Valid !== 1'b0 || bus0.In_Ready !== 1'b1 || bus0.Result !== 16'hFE01) begin
            err++;
            $display("FAIL release: Out_Valid=%b In_Ready=%b Result=%h, want 0 1 fe01",
                     bus0.Out_Valid, bus0.In_Ready, bus0.Result);
        end
    endtask

    task automatic test_reset_mid_wait();
        bus0.A = 8'd12; bus0.B = 8'd10; bus0.In_Valid = 1'b1;
        tick();
        bus0.In_Valid = 1'b0;
        tick();
        tick();
        #2 RSTn = 1'b0;
        #1;
        cmp++;
        if (bus0.Result !== 16'h0 || bus0.Out_Valid !== 1'b0 || bus0.In_Ready !== 1'b1 || bus0.Busy !== 1'b0) begin
            err++;
            $display("FAIL async_reset: Result=%h Out_Valid=%b In_Ready=%b Busy=%b, want 0000 0 1 0",
                     bus0.Result, bus0.Out_Valid, bus0.In_Ready, bus0.Busy);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            cmp++;
            if (bus0.Out_Valid !== 1'b0 || bus0.Result !== 16'h0) begin
                err++;
                $display("FAIL post_reset_%0d: Out_Valid=%b Result=%h, want 0 0000", i, bus0.Out_Valid, bus0.Result);
            end
        end
    endtask

`ifdef MCP_MULT_SIGNED_EN
    task automatic test_signed();
        for (int m = 1; m >= 0; m--) begin
            bus0.A = 8'h80; bus0.B = 8'h7F; bus0.Signed_Mode = m[0]; bus0.In_Valid = 1'b1;
            tick();
            bus0.In_Valid = 1'b0;
            bus0.Signed_Mode = ~m[0];
            repeat (M0) tick();
            cmp++;
            if (bus0.Out_Valid !== 1'b1 || bus0.Result !== ((m == 1) ? 16'hC080 : 16'h3F80)) begin
                err++;
                $display("FAIL signed_mode%0d: Out_Valid=%b Result=%h, want 1 %h",
                         m, bus0.Out_Valid, bus0.Result, ((m == 1) ? 16'hC080 : 16'h3F80));
            end
            bus0.Out_Ready = 1'b1;
            tick();
            bus0.Out_Ready = 1'b0;
        end
    endtask
`endif

    task automatic test_random(int n);
        for (int k = 0; k < n; k++) begin
            longint unsigned a;
            longint unsigned b;
            longint unsigned expv;
            bit sgn;
            int lat;
            bit got;
            int hold;
            sgn = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                bus0.In_Valid = 1'b0;
                bus0.A = W0'($urandom); bus0.B = W0'($urandom);
                tick();
            end
            a = longint'($urandom_range(0, 255));
            b = longint'($urandom_range(0, 255));
`ifdef MCP_MULT_SIGNED_EN
            sgn = 1'($urandom_range(0, 1));
            bus0.Signed_Mode = sgn;
`endif
            bus0.A = W0'(a); bus0.B = W0'(b); bus0.In_Valid = 1'b1;
            bus0.Out_Ready = 1'($urandom_range(0, 1));
            expv = ref_mul(a, b, W0, sgn);
            tick();
            lat = 0;
            got = 1'b0;
            // Operands, valid and ready keep changing while the product settles.
            while (!got && lat < M0 + 4) begin
                bus0.A = W0'($urandom); bus0.B = W0'($urandom);
                bus0.In_Valid  = 1'($urandom_range(0, 1));
                bus0.Out_Ready = 1'($urandom_range(0, 1));
`ifdef MCP_MULT_SIGNED_EN
                bus0.Signed_Mode = 1'($urandom_range(0, 1));
`endif
                tick();
                lat++;
                if (bus0.Out_Valid === 1'b1) got = 1'b1;
            end
            cmp++;
            if (!got || lat != M0) begin
                err++;
                $display("FAIL rand_latency_%0d: got=%0d after %0d edges, want %0d", k, got, lat, M0);
            end
            cmp++;
            if (bus0.Result !== W0'(0) + 16'(expv)) begin
                err++;
                $display("FAIL rand_product_%0d: %0d*%0d sgn=%0d Result=%h, want %h", k, a, b, sgn, bus0.Result, 16'(expv));
            end
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                bus0.Out_Ready = 1'b0;
                bus0.In_Valid  = 1'($urandom_range(0, 1));
                bus0.A = W0'($urandom); bus0.B = W0'($urandom);
                tick();
                cmp++;
                if (bus0.Out_Valid !== 1'b1 || bus0.Result !== 16'(expv)) begin
                    err++;
                    $display("FAIL rand_hold_%0d: Out_Valid=%b Result=%h, want 1 %h", k, bus0.Out_Valid, bus0.Result, 16'(expv));
                end
            end
            bus0.Out_Ready = 1'b1;
            bus0.In_Valid  = 1'($urandom_range(0, 1));
            tick();
            bus0.Out_Ready = 1'b0;
            bus0.In_Valid  = 1'b0;
            cmp++;
            if (bus0.Out_Valid !== 1'b0 || bus0.In_Ready !== 1'b1 || bus0.Result !== 16'(expv)) begin
                err++;
                $display("FAIL rand_release_%0d: Out_Valid=%b In_Ready=%b Result=%h, want 0 1 %h",
                         k, bus0.Out_Valid, bus0.In_Ready, bus0.Result, 16'(expv));
            end
        end
    endtask

    task automatic test_back_to_back();
        longint unsigned q[$];
        longint unsigned expv;
        int last_ov;
        int seen;
        last_ov = -1;
        seen = 0;
        bus0.In_Valid  = 1'b1;
        bus0.Out_Ready = 1'b1;
`ifdef MCP_MULT_SIGNED_EN
        bus0.Signed_Mode = 1'b0;
`endif
        for (int c = 0; c < 48; c++) begin
            longint unsigned a;
            longint unsigned b;
            a = longint'($urandom_range(0, 255));
            b = longint'($urandom_range(0, 255));
            bus0.A = W0'(a); bus0.B = W0'(b);
            if (c >= 40) bus0.In_Valid = 1'b0;
            if (bus0.In_Ready === 1'b1 && bus0.In_Valid === 1'b1) q.push_back(ref_mul(a, b, W0, 1'b0));
            tick();
            if (bus0.Out_Valid === 1'b1) begin
                seen++;
                expv = (q.size() > 0) ? q.pop_front() : 64'hFFFF_FFFF;
                cmp++;
                if (bus0.Result !== 16'(expv)) begin
                    err++;
                    $display("FAIL b2b_product_c%0d: Result=%h, want %h", c, bus0.Result, 16'(expv));
                end
                if (last_ov >= 0) begin
                    cmp++;
                    if (c - last_ov != M0 + 2) begin
                        err++;
                        $display("FAIL b2b_period_c%0d: gap=%0d, want %0d", c, c - last_ov, M0 + 2);
                    end
                end
                last_ov = c;
            end
        end
        bus0.Out_Ready = 1'b0;
        cmp++;
        if (q.size() != 0 || seen < 40 / (M0 + 2)) begin
            err++;
            $display("FAIL b2b_count: pending=%0d seen=%0d, want 0 and >=%0d", q.size(), seen, 40 / (M0 + 2));
        end
    endtask

    task automatic test_single_cycle();
        for (int k = 0; k < 6; k++) begin
            longint unsigned a;
            longint unsigned b;
            longint unsigned expv;
            a = (k == 0) ? 64'hFFFF : longint'($urandom_range(0, 65535));
            b = (k == 0) ? 64'h0002 : longint'($urandom_range(0, 65535));
            expv = ref_mul(a, b, W1, 1'b0);
            cmp++;
            if (bus1.In_Ready !== 1'b1) begin
                err++;
                $display("FAIL mc1_ready_%0d: In_Ready=%b, want 1", k, bus1.In_Ready);
            end
            bus1.A = W1'(a); bus1.B = W1'(b); bus1.In_Valid = 1'b1;
            tick();
            bus1.In_Valid = 1'b0;
            bus1.A = W1'($urandom); bus1.B = W1'($urandom);
            tick();
            cmp++;
            if (bus1.Out_Valid !== 1'b1 || bus1.Result !== 32'(expv)) begin
                err++;
                $display("FAIL mc1_product_%0d: Out_Valid=%b Result=%h, want 1 %h", k, bus1.Out_Valid, bus1.Result, 32'(expv));
            end
            bus1.Out_Ready = 1'b1;
            tick();
            bus1.Out_Ready = 1'b0;
            cmp++;
            if (bus1.Out_Valid !== 1'b0 || bus1.In_Ready !== 1'b1) begin
                err++;
                $display("FAIL mc1_release_%0d: Out_Valid=%b In_Ready=%b, want 0 1", k, bus1.Out_Valid, bus1.In_Ready);
            end
        end
    endtask

    initial begin
        bus0.A = '0; bus0.B = '0; bus0.In_Valid = 1'b0; bus0.Out_Ready = 1'b0;
        bus1.A = '0; bus1.B = '0; bus1.In_Valid = 1'b0; bus1.Out_Ready = 1'b0;
`ifdef MCP_MULT_SIGNED_EN
        bus0.Signed_Mode = 1'b0;
        bus1.Signed_Mode = 1'b0;
`endif
        test_reset();
        test_latency();
        test_hold();
        test_reset_mid_wait();
`ifdef MCP_MULT_SIGNED_EN
        test_signed();
`endif
        test_random(40);
        test_back_to_back();
        test_single_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
